cms_axis_downsizer: RTL and testbench
=====================================

# cms_axis_downsizer

AXI-Stream width downsizer and elastic buffer sitting directly downstream of `continuous_monitoring_system`. It consumes the wide trace packets (pc + instr, `AXI_DATA_WIDTH` bits) from its `M_AXIS` master and re-emits them as narrow words for the 32-bit DMA/FIFO path to the host, preserving packet boundaries (`tlast`). A small input FIFO absorbs bursts while the narrow side serialises each wide beat.

## Interface
- `IN_WIDTH`, 96: input beat width; must equal the upstream `AXI_DATA_WIDTH`.
- `OUT_WIDTH`, 32: output word width. `IN_WIDTH % OUT_WIDTH == 0` is required. `RATIO = IN_WIDTH/OUT_WIDTH` (≥1).
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `S_AXIS_tdata`  in  IN_WIDTH  wide beat from `continuous_monitoring_system`.
- `S_AXIS_tvalid`  in  1  input beat valid.
- `S_AXIS_tlast`  in  1  last beat of packet.
- `S_AXIS_tready`  out  1  FIFO not full.
- `M_AXIS_tdata`  out  OUT_WIDTH  narrow output word.
- `M_AXIS_tvalid`  out  1  output word valid.
- `M_AXIS_tlast`  out  1  last word of packet.
- `M_AXIS_tready`  in  1  downstream ready.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  entries currently in the FIFO.
- `words_sent`  out  32  count of output handshakes, wraps at 2^32.
- `packets_sent`  out  32  count of output handshakes with `tlast`, wraps at 2^32.

## Operation
- Input FIFO: push on `S_AXIS_tvalid && S_AXIS_tready`; stores {tlast, tdata}. `S_AXIS_tready = (fifo_level != FIFO_DEPTH)` and is driven from registered state only, with no combinational path from `M_AXIS_tready`.
- Serialiser: holding register plus slice index `idx` (0..RATIO-1) and a `busy` flag. States: IDLE (`busy=0`) and SHIFT (`busy=1`).
  - IDLE → SHIFT: FIFO non-empty; pop one entry, `idx=0`.
  - SHIFT, handshake with `idx<RATIO-1`: `idx++`.
  - SHIFT, handshake with `idx==RATIO-1`: if FIFO non-empty, pop and reload with `idx=0` in the same edge (no bubble); otherwise go to IDLE.
- `M_AXIS_tdata = hold[idx*OUT_WIDTH +: OUT_WIDTH]`, least-significant slice first (upstream instr word before pc).
- `M_AXIS_tvalid = busy`. `M_AXIS_tlast = busy && stored_tlast && idx==RATIO-1`.
- With RATIO=1, each beat passes through unchanged, with its `tlast`.
- Simultaneous push and pop: `fifo_level` unchanged. Push when full is impossible because `tready=0`. Pop when empty is impossible.
- `words_sent` increments on every output handshake. `packets_sent` increments when the handshake also has `M_AXIS_tlast`.
- Reset (any time, including mid-beat): pointers, `fifo_level`, `busy`, `idx`, and both counters clear immediately. Any partially sent beat and all FIFO contents are discarded.

## Timing
- Reset values: `S_AXIS_tready=1`, `M_AXIS_tvalid=0`, `M_AXIS_tlast=0`, `M_AXIS_tdata=0`, `fifo_level=0`, `words_sent=0`, `packets_sent=0`.
- Latency: a beat accepted at edge N (empty pipeline) produces `M_AXIS_tvalid=1` after edge N+1, with slice 0 on `tdata`.
- Throughput: one output word per cycle while `M_AXIS_tready=1`. Input sustains one beat per RATIO cycles.
- AXI-S rules: while `M_AXIS_tvalid && !M_AXIS_tready`, the outputs `tdata`/`tlast`/`tvalid` hold stable. `M_AXIS_tvalid` never depends combinationally on `M_AXIS_tready`.
- Total buffering is FIFO_DEPTH + 1 beats (FIFO plus holding register).

## Test plan
- Single beat: `tdata=96'hCCCCCCCC_BBBBBBBB_AAAAAAAA`, `tlast=1`, `M_AXIS_tready=1` -> words AAAAAAAA, BBBBBBBB, CCCCCCCC on 3 consecutive cycles starting after edge N+1; `tlast` only on CCCCCCCC; `words_sent=3`, `packets_sent=1`.
- Streaming: 10 back-to-back beats (tlast on the 10th), `M_AXIS_tready=1` -> 30 words on 30 consecutive cycles with no gaps; single `tlast` on word 30; `packets_sent=1`.
- Backpressure: toggle `M_AXIS_tready` pseudo-randomly over 8 beats -> `tdata` is stable while stalled, and a scoreboard sees all 24 words in order with none lost or duplicated.
- Full: `M_AXIS_tready=0`, continuous input -> exactly 5 beats accepted, then `S_AXIS_tready=0` and `fifo_level=4`. Raising `M_AXIS_tready` -> `S_AXIS_tready` reasserts after the first beat fully drains and the FIFO reloads.
- Reset mid-beat: assert `rst` asynchronously after word 2 of a beat -> `M_AXIS_tvalid` drops without waiting for a clock edge and counters read 0. After release, a new beat emits its slice 0 first.
- RATIO=1 (`IN_WIDTH=OUT_WIDTH=64`): beats 64'h1, 64'h2 with tlast on the second -> pass through unchanged with one-cycle latency; `tlast` on 64'h2 only.

Source files
------------

// File: rtl/cms_axis_downsizer.sv
// cms_axis_downsizer: wide-to-narrow AXI-Stream serialiser
// with a small input FIFO in front of the holding register.
module cms_axis_downsizer #(
  parameter int IN_WIDTH   = 96,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  input  logic                          S_AXIS_tlast,
  output logic                          S_AXIS_tready,
  output logic [OUT_WIDTH-1:0]          M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  output logic                          M_AXIS_tlast,
  input  logic                          M_AXIS_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   words_sent,
  output logic [31:0]                   packets_sent
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [IN_WIDTH:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  state_t              state;
  state_t              state_d;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    idx_d;
  logic [RATIO-1:0][OUT_WIDTH-1:0] hold;
  logic                hold_last;
  logic                push;
  logic                pop;
  logic                empty;
  logic                last_slice;
  logic                out_hs;
  logic [31:0]         words_q;
  logic [31:0]         packets_q;

  assign empty         = (level == '0);
  assign S_AXIS_tready = (level != FULL_LVL);
  assign push          = S_AXIS_tvalid && S_AXIS_tready;
  assign last_slice    = (idx == LAST_IDX);
  assign M_AXIS_tvalid = (state == SHIFT);
  assign M_AXIS_tlast  = M_AXIS_tvalid && hold_last && last_slice;
  assign M_AXIS_tdata  = hold[idx];
  assign out_hs        = M_AXIS_tvalid && M_AXIS_tready;
  assign fifo_level    = level;
  assign words_sent    = words_q;
  assign packets_sent  = packets_q;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {S_AXIS_tlast, S_AXIS_tdata};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Serialiser next state: load on idle, step slices, reload without bubble
  always_comb begin
    state_d = state;
    idx_d   = idx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = SHIFT;
          idx_d   = '0;
        end
      end
      SHIFT: begin
        if (out_hs) begin
          if (!last_slice) begin
            idx_d = idx + IDX_W'(1);
          end else if (!empty) begin
            pop   = 1'b1;
            idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Serialiser state, slice index and holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold      <= '0;
      hold_last <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (pop) begin
        hold      <= mem[rd_ptr][IN_WIDTH-1:0];
        hold_last <= mem[rd_ptr][IN_WIDTH];
      end
    end
  end

  // Output handshake statistics, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_q   <= '0;
      packets_q <= '0;
    end else if (out_hs) begin
      words_q <= words_q + 32'd1;
      if (M_AXIS_tlast) packets_q <= packets_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// tb_cms_axis_downsizer: vector table, random scoreboard runs
// and corner-case sequences for the 96->32 and 64->64 builds.
module tb_cms_axis_downsizer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [95:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic [2:0]  level;
  logic [31:0] words;
  logic [31:0] pkts;

  logic [63:0] b_s_data = '0;
  logic        b_s_valid = 1'b0;
  logic        b_s_last = 1'b0;
  logic        b_s_ready;
  logic [63:0] b_m_data;
  logic        b_m_valid;
  logic        b_m_last;
  logic        b_m_ready = 1'b0;
  logic [2:0]  b_level;
  logic [31:0] b_words;
  logic [31:0] b_pkts;

  cms_axis_downsizer dut (
    .clk(clk), .rst(rst),
    .S_AXIS_tdata(s_data), .S_AXIS_tvalid(s_valid),
    .S_AXIS_tlast(s_last), .S_AXIS_tready(s_ready),
    .M_AXIS_tdata(m_data), .M_AXIS_tvalid(m_valid),
    .M_AXIS_tlast(m_last), .M_AXIS_tready(m_ready),
    .fifo_level(level), .words_sent(words),
    .packets_sent(pkts)
  );

  cms_axis_downsizer #(
    .IN_WIDTH(64), .OUT_WIDTH(64), .FIFO_DEPTH(4)
  ) dut_r1 (
    .clk(clk), .rst(rst),
    .S_AXIS_tdata(b_s_data), .S_AXIS_tvalid(b_s_valid),
    .S_AXIS_tlast(b_s_last), .S_AXIS_tready(b_s_ready),
    .M_AXIS_tdata(b_m_data), .M_AXIS_tvalid(b_m_valid),
    .M_AXIS_tlast(b_m_last), .M_AXIS_tready(b_m_ready),
    .fifo_level(b_level), .words_sent(b_words),
    .packets_sent(b_pkts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  typedef struct {
    logic [95:0] d;
    logic        l;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  int    n_pass = 0;
  int    n_total = 0;
  word_t expq[$];
  int    exp_w = 0;
  int    exp_p = 0;
  bit    sb_on = 0;
  bit    stall_prev = 0;
  logic [31:0] prev_data;
  logic        prev_last;
  int    cyc = 0;
  int    hs_cnt = 0;
  int    hs_first = -1;
  int    hs_last = -1;
  int    tl_cnt = 0;

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  // one clock: scoreboard at negedge, then advance
  task automatic step();
    word_t w;
    if (sb_on) begin
      if (stall_prev) begin
        check("stable_valid", m_valid, 1);
        check("stable_data", m_data, prev_data);
        check("stable_last", m_last, prev_last);
      end
      if (s_valid && s_ready) begin
        for (int r = 0; r < 3; r++) begin
          w.d = s_data[r*32 +: 32];
          w.l = s_last && (r == 2);
          expq.push_back(w);
        end
        exp_w += 3;
        if (s_last) exp_p++;
      end
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = cyc;
        hs_last = cyc;
        if (m_last) tl_cnt++;
        if (expq.size() == 0) begin
          check("sb_spurious", 1, 0);
        end else begin
          w = expq.pop_front();
          check("sb_data", m_data, w.d);
          check("sb_last", m_last, w.l);
        end
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    s_valid = 0;
    b_s_valid = 0;
    m_ready = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    expq.delete();
    exp_w = 0;
    exp_p = 0;
    stall_prev = 0;
    hs_cnt = 0;
    hs_first = -1;
    hs_last = -1;
    tl_cnt = 0;
  endtask

  task automatic drain(bit rnd);
    int g = 0;
    while ((expq.size() != 0 || m_valid) && g < 500) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      g++;
    end
    check("drain_done", expq.size(), 0);
    check("drain_idle", m_valid, 0);
  endtask

  task automatic run_beats(int n, int last_at, bit rnd);
    int  sent = 0;
    int  g = 0;
    bit  acc;
    s_valid = 1;
    s_data  = rnd96();
    s_last  = (last_at == 1);
    while (sent < n && g < 2000) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = s_valid && s_ready;
      step();
      if (acc) begin
        sent++;
        s_data = rnd96();
        s_last = (sent + 1 == last_at);
        if (sent == n) s_valid = 0;
      end
      g++;
    end
    check("beats_sent", sent, n);
    drain(rnd);
  endtask

  vec_t tbl [4];

  initial begin
    int acc_cnt;
    int tl_sum;
    bit acc;
    logic [95:0] beat;

    tbl[0] = '{96'hCCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b1,
               32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC};
    tbl[1] = '{96'h00000003_00000002_00000001, 1'b0,
               32'h00000001, 32'h00000002, 32'h00000003};
    tbl[2] = '{96'hFFFFFFFF_00000000_FFFFFFFF, 1'b1,
               32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
    tbl[3] = '{96'h12345678_9ABCDEF0_0F1E2D3C, 1'b0,
               32'h0F1E2D3C, 32'h9ABCDEF0, 32'h12345678};

    @(negedge clk);
    do_reset();
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_level", level, 0);
    check("rst_words", words, 0);
    check("rst_pkts", pkts, 0);
    check("rst_r1_valid", b_m_valid, 0);

    // table-driven single beats
    sb_on = 0;
    tl_sum = 0;
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      s_data = tbl[i].d;
      s_last = tbl[i].l;
      s_valid = 1;
      step();
      s_valid = 0;
      check("tbl_lat_v0", m_valid, 0);
      step();
      check("tbl_v_w0", m_valid, 1);
      check("tbl_w0", m_data, tbl[i].w0);
      check("tbl_l_w0", m_last, 0);
      step();
      check("tbl_w1", m_data, tbl[i].w1);
      check("tbl_l_w1", m_last, 0);
      step();
      check("tbl_w2", m_data, tbl[i].w2);
      check("tbl_l_w2", m_last, tbl[i].l);
      step();
      check("tbl_idle", m_valid, 0);
      if (tbl[i].l) tl_sum++;
      check("tbl_words", words, 3 * (i + 1));
      check("tbl_pkts", pkts, tl_sum);
    end

    // streaming: 10 beats, tlast on the 10th
    do_reset();
    sb_on = 1;
    run_beats(10, 10, 0);
    check("strm_hs", hs_cnt, 30);
    check("strm_nogap", hs_last - hs_first, 29);
    check("strm_tlast", tl_cnt, 1);
    check("strm_words", words, exp_w);
    check("strm_pkts", pkts, 1);

    // backpressure: random ready over 8 beats
    for (int k = 0; k < 3; k++) begin
      do_reset();
      run_beats(8, 4 + k, 1);
      check("bp_words", words, 24);
      check("bp_pkts", pkts, exp_p);
    end

    // full: stalled output, continuous input
    do_reset();
    m_ready = 0;
    s_valid = 1;
    s_data = rnd96();
    s_last = 1'($urandom_range(0, 1));
    acc_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      acc = s_valid && s_ready;
      step();
      if (acc) begin
        acc_cnt++;
        s_data = rnd96();
        s_last = 1'($urandom_range(0, 1));
      end
    end
    check("full_accepted", acc_cnt, 5);
    check("full_s_ready", s_ready, 0);
    check("full_level", level, 4);
    s_valid = 0;
    m_ready = 1;
    step();
    check("full_rdy_e1", s_ready, 0);
    step();
    check("full_rdy_e2", s_ready, 0);
    step();
    check("full_rdy_e3", s_ready, 1);
    check("full_level3", level, 3);
    drain(0);
    check("full_words", words, 15);
    check("full_pkts", pkts, exp_p);

    // asynchronous reset after word 2 of a beat
    do_reset();
    sb_on = 0;
    m_ready = 1;
    s_data = 96'h33333333_22222222_11111111;
    s_last = 1;
    s_valid = 1;
    step();
    s_valid = 0;
    step();
    step();
    step();
    check("mid_pre_words", words, 2);
    check("mid_pre_data", m_data, 32'h33333333);
    #2 rst = 1;
    #1;
    check("mid_valid", m_valid, 0);
    check("mid_last", m_last, 0);
    check("mid_words", words, 0);
    check("mid_pkts", pkts, 0);
    check("mid_level", level, 0);
    check("mid_s_ready", s_ready, 1);
    @(negedge clk);
    rst = 0;
    beat = 96'h66666666_55555555_44444444;
    s_data = beat;
    s_last = 0;
    s_valid = 1;
    step();
    s_valid = 0;
    check("mid_new_v0", m_valid, 0);
    step();
    check("mid_new_v1", m_valid, 1);
    check("mid_new_w0", m_data, 32'h44444444);
    step();
    check("mid_new_w1", m_data, 32'h55555555);

    // RATIO=1 passthrough build
    do_reset();
    b_m_ready = 1;
    b_s_valid = 1;
    b_s_data = 64'h1;
    b_s_last = 0;
    step();
    check("r1_lat_v0", b_m_valid, 0);
    b_s_data = 64'h2;
    b_s_last = 1;
    step();
    b_s_valid = 0;
    check("r1_v1", b_m_valid, 1);
    check("r1_d1", b_m_data, 64'h1);
    check("r1_l1", b_m_last, 0);
    step();
    check("r1_v2", b_m_valid, 1);
    check("r1_d2", b_m_data, 64'h2);
    check("r1_l2", b_m_last, 1);
    step();
    check("r1_idle", b_m_valid, 0);
    check("r1_words", b_words, 2);
    check("r1_pkts", b_pkts, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
